ir_emitter: RTL

//  Transmit side of the IR link: drives the IR LED with bursts of modulated carrier for the paddle/ball IR sensor.

---
 rtl/ir_emitter_if.sv | 29 ++
 rtl/ir_emitter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ir_emitter_if.sv
// ir_emitter_if -- request/status bundle between game logic and the IR emitter.
//   master : game logic side (drives start, burst_len, repeat_en)
//   slave  : ir_emitter side (drives ir_led, busy, done, frame_cnt)
//   start      1  request one frame (honoured only while idle)
//   burst_len  8  carrier periods per mark
//   repeat_en  1  chain another frame when the current space ends
//   ir_led     1  LED drive, 1 = on
//   busy       1  high during mark and space
//   done       1  one-cycle pulse on return to idle
//   frame_cnt  8  frames completed since reset, modulo 256
interface ir_emitter_if;
    logic       start;
    logic [7:0] burst_len;
    logic       repeat_en;
    logic       ir_led;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    modport master (
        output start, burst_len, repeat_en,
        input  ir_led, busy, done, frame_cnt
    );

    modport slave (
        input  start, burst_len, repeat_en,
        output ir_led, busy, done, frame_cnt
    );
endinterface

// File: rtl/ir_emitter.sv
// ir_emitter -- IR LED burst generator: a mark of burst_len carrier periods
// followed by a fixed space of GAP_CYCLES clocks, optionally chained.
//   i_clk_100MHz  system clock, rising edge
//   i_reset       synchronous, active-high
//   ir_if         ir_emitter_if.slave (start/burst_len/repeat_en in,
//                 ir_led/busy/done/frame_cnt out, all outputs registered)
// Build option: define IR_EMITTER_CARRIER_EN to modulate the mark at
// CARRIER_HZ; without it the LED is held on for the whole mark (same timing).
//
// state | meaning
// IDLE  | waiting for start with non-zero burst_len
// MARK  | emitting burst_len carrier periods
// SPACE | LED off for GAP_CYCLES clocks, then repeat or return to IDLE
module ir_emitter #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int CARRIER_HZ = 38_000,
    parameter int GAP_CYCLES = 20_000
) (
    input  logic          i_clk_100MHz,
    input  logic          i_reset,
    ir_emitter_if.slave   ir_if
);

    localparam int HALF_PERIOD = CLK_HZ / (2 * CARRIER_HZ);
    localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HC_W-1:0] HC_TC = HC_W'(HALF_PERIOD - 1);
    localparam logic [GC_W-1:0] GC_TC = GC_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    state_t          r_state,      w_state;
    logic [HC_W-1:0] r_half_cnt,   w_half_cnt;
    logic [7:0]      r_period_cnt, w_period_cnt;
    logic [GC_W-1:0] r_gap_cnt,    w_gap_cnt;
    logic [7:0]      r_burst,      w_burst;
    logic            r_phase,      w_phase;
    logic            r_led,        w_led;
    logic            r_busy,       w_busy;
    logic            r_done,       w_done;
    logic [7:0]      r_frame_cnt,  w_frame_cnt;
    logic [7:0]      w_period_inc;

    assign w_period_inc = r_period_cnt + 8'd1;

    always_comb begin
        w_state      = r_state;
        w_half_cnt   = r_half_cnt;
        w_period_cnt = r_period_cnt;
        w_gap_cnt    = r_gap_cnt;
        w_burst      = r_burst;
        w_phase      = r_phase;
        w_frame_cnt  = r_frame_cnt;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ir_if.start && (ir_if.burst_len != 8'd0)) begin
                    w_state      = S_MARK;
                    w_burst      = ir_if.burst_len;
                    w_half_cnt   = '0;
                    w_period_cnt = 8'd0;
                    w_phase      = 1'b1;
                end
            end
            S_MARK: begin
                if (r_half_cnt == HC_TC) begin
                    w_half_cnt = '0;
                    w_phase    = ~r_phase;
                    // Low->high edge closes one full carrier period.
                    if (!r_phase) begin
                        w_period_cnt = w_period_inc;
                        if (w_period_inc == r_burst) begin
                            w_state   = S_SPACE;
                            w_phase   = 1'b0;
                            w_gap_cnt = '0;
                        end
                    end
                end else begin
                    w_half_cnt = r_half_cnt + HC_W'(1);
                end
            end
            S_SPACE: begin
                if (r_gap_cnt == GC_TC) begin
                    w_frame_cnt = r_frame_cnt + 8'd1;
                    w_gap_cnt   = '0;
                    if (ir_if.repeat_en && (ir_if.burst_len != 8'd0)) begin
                        w_state      = S_MARK;
                        w_burst      = ir_if.burst_len;
                        w_half_cnt   = '0;
                        w_period_cnt = 8'd0;
                        w_phase      = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_gap_cnt = r_gap_cnt + GC_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
`ifdef IR_EMITTER_CARRIER_EN
        w_led  = (w_state == S_MARK) && w_phase;
`else
        // Phase still tracks internally so the mark length is unchanged.
        w_led  = (w_state == S_MARK);
`endif
    end

    always_ff @(posedge i_clk_100MHz) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_half_cnt   <= '0;
            r_period_cnt <= 8'd0;
            r_gap_cnt    <= '0;
            r_burst      <= 8'd0;
            r_phase      <= 1'b0;
            r_led        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state;
            r_half_cnt   <= w_half_cnt;
            r_period_cnt <= w_period_cnt;
            r_gap_cnt    <= w_gap_cnt;
            r_burst      <= w_burst;
            r_phase      <= w_phase;
            r_led        <= w_led;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_frame_cnt  <= w_frame_cnt;
        end
    end

    assign ir_if.ir_led    = r_led;
    assign ir_if.busy      = r_busy;
    assign ir_if.done      = r_done;
    assign ir_if.frame_cnt = r_frame_cnt;

endmodule
